var_clk_div: RTL and testbench

//   Parametrised power-of-two clock divider for the FPGA client. Produces a

---
 rtl/var_clk_div.sv | 108 ++++++++++
 tb/tb_var_clk_div.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/var_clk_div.sv
// rtl/var_clk_div.sv - power-of-two clock divider with rise/fall strobes
// Ratio and enable changes take effect only at period boundaries.
module var_clk_div #(
    parameter int SEL_W   = 4,
    parameter int MAX_SEL = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] selector,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [SEL_W-1:0] sel_cur,
    output logic             sel_upd,
    output logic             running
);

    localparam int CNT_W = (MAX_SEL > 1) ? MAX_SEL : 1;
    localparam logic [SEL_W-1:0] MAX_SEL_V = SEL_W'(MAX_SEL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term_cnt;
    logic [CNT_W:0]   half;
    logic [SEL_W-1:0] sel_req;
    logic             at_term;
    logic             sel_diff;

    // half is one bit wider so H = 2^MAX_SEL still yields term_cnt = all ones
    always_comb begin
        sel_req  = (selector > MAX_SEL_V) ? MAX_SEL_V : selector;
        half     = (CNT_W+1)'(1) << sel_cur;
        term_cnt = CNT_W'(half - (CNT_W+1)'(1));
        at_term  = (cnt == term_cnt);
        sel_diff = (sel_req != sel_cur);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            clk_out  <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            sel_cur  <= '0;
            sel_upd  <= 1'b0;
            running  <= 1'b0;
        end else begin
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            sel_upd  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    clk_out <= 1'b0;
                    if (en) begin
                        state    <= RUN;
                        running  <= 1'b1;
                        clk_out  <= 1'b1;
                        rise_stb <= 1'b1;
                        if (sel_diff) begin
                            sel_cur <= sel_req;
                            sel_upd <= 1'b1;
                        end
                    end
                end
                RUN, STOP: begin
                    state <= en ? RUN : STOP;
                    if (!at_term) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (clk_out) begin
                            clk_out  <= 1'b0;
                            fall_stb <= 1'b1;
                        end else if (state == STOP && !en) begin
                            // stop completes on the boundary: no further rise
                            state   <= IDLE;
                            running <= 1'b0;
                        end else begin
                            clk_out  <= 1'b1;
                            rise_stb <= 1'b1;
                            // a stop requested at this boundary freezes the ratio
                            if (en && sel_diff) begin
                                sel_cur <= sel_req;
                                sel_upd <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    clk_out <= 1'b0;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_var_clk_div.sv
// tb/tb_var_clk_div.sv - directed self-checking bench for var_clk_div
module tb_var_clk_div;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       en12 = 1'b0;
    logic [3:0] selector = 4'd0;
    logic [3:0] selector12 = 4'd0;
    logic       clk_out, rise_stb, fall_stb, sel_upd, running;
    logic [3:0] sel_cur;
    logic       clk_out12, rise_stb12, fall_stb12, sel_upd12, running12;
    logic [3:0] sel_cur12;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    var_clk_div #(.SEL_W(4), .MAX_SEL(15)) dut (
        .clk(clk), .rst(rst), .en(en), .selector(selector),
        .clk_out(clk_out), .rise_stb(rise_stb), .fall_stb(fall_stb),
        .sel_cur(sel_cur), .sel_upd(sel_upd), .running(running)
    );

    var_clk_div #(.SEL_W(4), .MAX_SEL(12)) dut12 (
        .clk(clk), .rst(rst), .en(en12), .selector(selector12),
        .clk_out(clk_out12), .rise_stb(rise_stb12), .fall_stb(fall_stb12),
        .sel_cur(sel_cur12), .sel_upd(sel_upd12), .running(running12)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({clk_out, rise_stb, fall_stb, sel_upd, running, sel_cur} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {clk_out, rise_stb, fall_stb, sel_upd, running, sel_cur});
        end
        rst = 1'b0;
    endtask

    task automatic test_sel0();
        do_reset();
        selector = 4'd0;
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (clk_out !== i[0]) begin
                errors++;
                $display("FAIL sel0_clk i=%0d got=%b exp=%b", i, clk_out, i[0]);
            end
            checks++;
            if (rise_stb !== i[0] || fall_stb !== !i[0]) begin
                errors++;
                $display("FAIL sel0_strobes i=%0d got=%b%b exp=%b%b", i, rise_stb, fall_stb, i[0], !i[0]);
            end
        end
        checks++;
        if (sel_upd !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL sel0_status got upd=%b run=%b exp upd=0 run=1", sel_upd, running);
        end
        en = 1'b0;
    endtask

    task automatic test_sel2();
        int rises = 0;
        int falls = 0;
        logic exp_clk;
        do_reset();
        selector = 4'd2;
        en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_clk = ((i - 1) % 8) < 4;
            if (rise_stb) rises++;
            if (fall_stb) falls++;
            checks++;
            if (clk_out !== exp_clk) begin
                errors++;
                $display("FAIL sel2_clk i=%0d got=%b exp=%b", i, clk_out, exp_clk);
            end
            if (i == 1) begin
                checks++;
                if (sel_upd !== 1'b1 || sel_cur !== 4'd2) begin
                    errors++;
                    $display("FAIL sel2_start got upd=%b cur=%0d exp upd=1 cur=2", sel_upd, sel_cur);
                end
            end
        end
        checks++;
        if (rises !== 2 || falls !== 2) begin
            errors++;
            $display("FAIL sel2_strobe_count got rise=%0d fall=%0d exp 2/2", rises, falls);
        end
        en = 1'b0;
    endtask

    task automatic test_sel_change();
        logic exp_clk;
        logic exp_upd;
        logic [3:0] exp_cur;
        do_reset();
        selector = 4'd2;
        en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 2) selector = 4'd1;
            exp_clk = (i <= 8) ? (((i - 1) % 8) < 4) : (((i - 9) % 4) < 2);
            exp_upd = (i == 1) || (i == 9);
            exp_cur = (i < 9) ? 4'd2 : 4'd1;
            checks++;
            if (clk_out !== exp_clk || sel_upd !== exp_upd || sel_cur !== exp_cur) begin
                errors++;
                $display("FAIL selchg i=%0d got clk=%b upd=%b cur=%0d exp clk=%b upd=%b cur=%0d",
                         i, clk_out, sel_upd, sel_cur, exp_clk, exp_upd, exp_cur);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_max_clamp();
        int hi;
        int lo;
        int n;
        do_reset();
        selector12 = 4'd15;
        en12 = 1'b1;
        tick();
        checks++;
        if (sel_cur12 !== 4'd12 || clk_out12 !== 1'b1 || sel_upd12 !== 1'b1) begin
            errors++;
            $display("FAIL clamp_start got cur=%0d clk=%b upd=%b exp cur=12 clk=1 upd=1", sel_cur12, clk_out12, sel_upd12);
        end
        hi = 1;
        n = 0;
        while (n < 5000) begin
            tick();
            n++;
            if (clk_out12 !== 1'b1) break;
            hi++;
        end
        checks++;
        if (hi !== 4096 || fall_stb12 !== 1'b1) begin
            errors++;
            $display("FAIL clamp_high got=%0d fall=%b exp=4096 fall=1", hi, fall_stb12);
        end
        lo = 1;
        n = 0;
        while (n < 5000) begin
            tick();
            n++;
            if (clk_out12 !== 1'b0) break;
            lo++;
        end
        checks++;
        if (lo !== 4096 || rise_stb12 !== 1'b1) begin
            errors++;
            $display("FAIL clamp_low got=%0d rise=%b exp=4096 rise=1", lo, rise_stb12);
        end
        en12 = 1'b0;
    endtask

    task automatic test_stop();
        logic exp_clk;
        logic exp_run;
        do_reset();
        selector = 4'd1;
        en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) en = 1'b0;
            exp_clk = (i <= 2);
            exp_run = (i <= 4);
            checks++;
            if (clk_out !== exp_clk || running !== exp_run || (i >= 5 && rise_stb !== 1'b0)) begin
                errors++;
                $display("FAIL stop i=%0d got clk=%b run=%b rise=%b exp clk=%b run=%b rise=0",
                         i, clk_out, running, rise_stb, exp_clk, exp_run);
            end
        end
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) en = 1'b0;
            if (i == 2) en = 1'b1;
            exp_clk = ((i - 1) % 4) < 2;
            checks++;
            if (clk_out !== exp_clk || running !== 1'b1) begin
                errors++;
                $display("FAIL stop_resume i=%0d got clk=%b run=%b exp clk=%b run=1", i, clk_out, running, exp_clk);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        selector = 4'd3;
        en = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (clk_out !== 1'b1 || sel_cur !== 4'd3) begin
            errors++;
            $display("FAIL arst_pre got clk=%b cur=%0d exp clk=1 cur=3", clk_out, sel_cur);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (clk_out !== 1'b0 || running !== 1'b0 || sel_cur !== 4'd0) begin
            errors++;
            $display("FAIL arst_immediate got clk=%b run=%b cur=%0d exp 0/0/0", clk_out, running, sel_cur);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (clk_out !== 1'b1 || rise_stb !== 1'b1 || sel_cur !== 4'd3 || sel_upd !== 1'b1) begin
            errors++;
            $display("FAIL arst_restart got clk=%b rise=%b cur=%0d upd=%b exp 1/1/3/1", clk_out, rise_stb, sel_cur, sel_upd);
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sel0();
        test_sel2();
        test_sel_change();
        test_max_clamp();
        test_stop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
